proc_bus_tracer: RTL and testbench

// Passive downstream monitor on the proc <-> memory_block bus.

---
 rtl/proc_bus_tracer.sv | 139 +++++++++++++
 tb/tb_proc_bus_tracer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_bus_tracer.sv
// Passive trace monitor for the proc <-> memory_block bus.
// Ring-buffer recording with address trigger, post-trigger window and FWFT drain.
module proc_bus_tracer #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int POST_TRIG = 32,
  parameter int TS_W      = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [15:0]       bus_address,
  input  logic [7:0]        bus_rd_data,
  input  logic [7:0]        bus_wr_data,
  input  logic              bus_wr_enable,
  input  logic              arm,
  input  logic              disarm,
  input  logic [15:0]       trig_addr,
  input  logic              trig_on_write,
  input  logic              rd_en,
  output logic [24+TS_W:0]  trace_data,
  output logic              trace_valid,
  output logic [ADDR_W:0]   trace_count,
  output logic [1:0]        state
);

  localparam int EW = 25 + TS_W;
  localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PT_M1 = (ADDR_W+1)'(POST_TRIG - 1);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     post_q, post_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic                match;
  logic                full;
  logic                go_arm;
  logic                wr_en;
  logic [EW-1:0]       wr_entry;
  logic [EW-1:0]       ram [DEPTH];

  always_comb begin
    match    = (bus_address == trig_addr) &&
               (!trig_on_write || bus_wr_enable);
    full     = (cnt_q == FULL);
    go_arm   = arm && (state_q == S_IDLE || state_q == S_DONE);
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    post_d   = post_q;
    wr_en    = 1'b0;
    // Entries carry the timestamp of the edge that records them.
    ts_d     = (go_arm && !disarm) ? '0 : ts_q + 1'b1;
    wr_entry = {bus_wr_enable, bus_address,
                bus_wr_enable ? bus_wr_data : bus_rd_data,
                ts_d};
    if (disarm) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      post_d   = '0;
    end else if (go_arm) begin
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      post_d   = '0;
    end else begin
      unique case (state_q)
        S_ARMED, S_CAPTURE: begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (full) rd_ptr_d = rd_ptr_q + 1'b1;
          else      cnt_d    = cnt_q + 1'b1;
          if (state_q == S_ARMED) begin
            if (match) begin
              if (POST_TRIG == 1) begin
                state_d = S_DONE;
              end else begin
                state_d = S_CAPTURE;
                post_d  = PT_M1;
              end
            end
          end else begin
            post_d = post_q - 1'b1;
            if (post_q == ONE) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (rd_en && trace_valid) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d    = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      post_q   <= '0;
      ts_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      post_q   <= post_d;
      ts_q     <= ts_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr_q] <= wr_entry;
  end

  // Head is masked when empty so unwritten RAM never leaks out.
  assign trace_valid = (state_q == S_DONE) && (cnt_q != '0);
  assign trace_data  = trace_valid ? ram[rd_ptr_q] : '0;
  assign trace_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_proc_bus_tracer.sv
// Bench for proc_bus_tracer: two instances (deep and shallow ring)
// checked against a queue-based trace model.
module tb_proc_bus_tracer;

  typedef logic [40:0] ent_t;

  logic        clk;
  logic        resetn;
  logic [15:0] bus_address;
  logic [7:0]  bus_rd_data;
  logic [7:0]  bus_wr_data;
  logic        bus_wr_enable;
  logic        arm;
  logic        disarm;
  logic [15:0] trig_addr;
  logic        trig_on_write;
  logic        rd_en;

  logic [40:0] td0, td1;
  logic        tv0, tv1;
  logic [6:0]  tc0;
  logic [3:0]  tc1;
  logic [1:0]  st0, st1;

  int n_chk;
  int n_fail;

  int   ms   [2];
  int   mpost[2];
  logic [15:0] mts[2];
  ent_t mq0[$];
  ent_t mq1[$];

  proc_bus_tracer #(
    .DEPTH(64), .ADDR_W(6), .POST_TRIG(4), .TS_W(16)
  ) u_big (
    .clk(clk), .resetn(resetn),
    .bus_address(bus_address), .bus_rd_data(bus_rd_data),
    .bus_wr_data(bus_wr_data), .bus_wr_enable(bus_wr_enable),
    .arm(arm), .disarm(disarm),
    .trig_addr(trig_addr), .trig_on_write(trig_on_write),
    .rd_en(rd_en),
    .trace_data(td0), .trace_valid(tv0),
    .trace_count(tc0), .state(st0)
  );

  proc_bus_tracer #(
    .DEPTH(8), .ADDR_W(3), .POST_TRIG(4), .TS_W(16)
  ) u_small (
    .clk(clk), .resetn(resetn),
    .bus_address(bus_address), .bus_rd_data(bus_rd_data),
    .bus_wr_data(bus_wr_data), .bus_wr_enable(bus_wr_enable),
    .arm(arm), .disarm(disarm),
    .trig_addr(trig_addr), .trig_on_write(trig_on_write),
    .rd_en(rd_en),
    .trace_data(td1), .trace_valid(tv1),
    .trace_count(tc1), .state(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ms[m]    = 0;
      mpost[m] = 0;
      mts[m]   = 16'h0;
    end
    mq0.delete();
    mq1.delete();
  endtask

  // One clock edge of the trace model for instance m (ring depth d).
  task automatic mstep(input int m, input int d);
    ent_t q[$];
    ent_t e;
    logic [15:0] t;
    logic hit;
    logic acc;
    q   = (m == 0) ? mq0 : mq1;
    t   = mts[m] + 16'd1;
    e   = {bus_wr_enable, bus_address,
           bus_wr_enable ? bus_wr_data : bus_rd_data, t};
    hit = (bus_address == trig_addr) &&
          (!trig_on_write || bus_wr_enable);
    acc = !disarm && arm && (ms[m] == 0 || ms[m] == 3);
    if (disarm) begin
      ms[m] = 0;
      q.delete();
    end else if (acc) begin
      ms[m] = 1;
      q.delete();
    end else if (ms[m] == 1 || ms[m] == 2) begin
      q.push_back(e);
      if (q.size() > d) void'(q.pop_front());
      if (ms[m] == 1) begin
        if (hit) begin
          ms[m]    = 2;
          mpost[m] = 3;
        end
      end else begin
        mpost[m]--;
        if (mpost[m] == 0) ms[m] = 3;
      end
    end else if (ms[m] == 3) begin
      if (rd_en && q.size() > 0) void'(q.pop_front());
    end
    mts[m] = acc ? 16'h0 : t;
    if (m == 0) mq0 = q;
    else        mq1 = q;
  endtask

  task automatic check_all();
    chk("state0", 64'(st0), 64'(ms[0]));
    chk("count0", 64'(tc0), 64'(mq0.size()));
    chk("valid0", 64'(tv0), 64'(ms[0] == 3 && mq0.size() > 0));
    if (ms[0] == 3 && mq0.size() > 0)
      chk("data0", 64'(td0), 64'(mq0[0]));
    chk("state1", 64'(st1), 64'(ms[1]));
    chk("count1", 64'(tc1), 64'(mq1.size()));
    chk("valid1", 64'(tv1), 64'(ms[1] == 3 && mq1.size() > 0));
    if (ms[1] == 3 && mq1.size() > 0)
      chk("data1", 64'(td1), 64'(mq1[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!resetn) begin
      model_reset();
    end else begin
      mstep(0, 64);
      mstep(1, 8);
    end
    #1;
    check_all();
  endtask

  task automatic bus_rd(input logic [15:0] a);
    bus_address   = a;
    bus_wr_enable = 1'b0;
    bus_rd_data   = 8'($urandom);
    bus_wr_data   = 8'($urandom);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] v);
    bus_address   = a;
    bus_wr_enable = 1'b1;
    bus_wr_data   = v;
    bus_rd_data   = 8'($urandom);
  endtask

  function automatic logic [15:0] rand_addr();
    return {4'h1, 12'($urandom)};
  endfunction

  task automatic rnd_bus();
    if ($urandom % 2 == 0) bus_rd(rand_addr());
    else bus_wr(rand_addr(), 8'($urandom));
  endtask

  logic [7:0]  rd0, rd6;
  logic [15:0] prev_ts;

  initial begin
    n_chk = 0;
    n_fail = 0;
    resetn = 1'b0;
    arm = 1'b0;
    disarm = 1'b0;
    rd_en = 1'b0;
    trig_addr = 16'h0200;
    trig_on_write = 1'b1;
    bus_rd(16'h0000);
    model_reset();

    // Reset held with bus activity, then release
    repeat (5) begin
      rnd_bus();
      arm = 1'($urandom);
      tick();
    end
    chk("rst_state", 64'(st0), 64'd0);
    chk("rst_count", 64'(tc0), 64'd0);
    arm = 1'b0;
    resetn = 1'b1;
    repeat (4) begin
      rnd_bus();
      tick();
    end
    chk("idle_hold", 64'(st0), 64'd0);

    // Basic capture
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus_rd(16'(16'h0100 + i));
      if (i == 0) rd0 = bus_rd_data;
      if (i == 6) rd6 = bus_rd_data;
      tick();
    end
    bus_wr(16'h0200, 8'hA5);
    tick();
    chk("t2_capture", 64'(st0), 64'd2);
    repeat (3) begin
      bus_rd(rand_addr());
      tick();
    end
    chk("t2_done", 64'(st0), 64'd3);
    chk("t2_count", 64'(tc0), 64'd14);
    chk("t2_head", 64'(td0), 64'({1'b0, 16'h0100, rd0, 16'd1}));
    chk("t3_small_head", 64'(td1),
        64'({1'b0, 16'h0106, rd6, 16'd7}));

    // Drain with rd_en held 20 cycles
    rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 10)
        chk("t2_trig_entry", 64'(td0),
            64'({1'b1, 16'h0200, 8'hA5, 16'd11}));
      rnd_bus();
      tick();
    end
    chk("t6_count", 64'(tc0), 64'd0);
    chk("t6_valid", 64'(tv0), 64'd0);
    rd_en = 1'b0;

    // Wrap on the shallow ring
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (20) begin
      bus_rd(rand_addr());
      tick();
    end
    bus_wr(16'h0200, 8'($urandom));
    tick();
    repeat (5) begin
      rnd_bus();
      tick();
    end
    chk("t3_count", 64'(tc1), 64'd8);
    chk("t3_first_ts", 64'(td1[15:0]), 64'd17);
    prev_ts = 16'd17;
    rd_en = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("t3_ts_seq", 64'(td1[15:0]), 64'(prev_ts + 16'd1));
      prev_ts = prev_ts + 16'd1;
    end
    tick();
    rd_en = 1'b0;

    // Trigger qualification
    trig_on_write = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (3) begin
      bus_rd(rand_addr());
      tick();
    end
    bus_rd(16'h0200);
    tick();
    chk("t4_read_ignored", 64'(st0), 64'd1);
    bus_rd(rand_addr());
    tick();
    bus_wr(16'h0200, 8'h3C);
    tick();
    chk("t4_write_trig", 64'(st0), 64'd2);
    trig_on_write = 1'b0;
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    bus_rd(rand_addr());
    tick();
    bus_rd(16'h0200);
    tick();
    chk("t4_any_trig", 64'(st0), 64'd2);

    // Abort from CAPTURE, then arm+disarm from DONE
    bus_rd(rand_addr());
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    chk("t5_idle", 64'(st0), 64'd0);
    chk("t5_count", 64'(tc0), 64'd0);
    chk("t5_valid", 64'(tv0), 64'd0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    bus_rd(16'h0200);
    tick();
    repeat (5) begin
      bus_rd(rand_addr());
      tick();
    end
    chk("t5_done", 64'(st0), 64'd3);
    arm = 1'b1;
    disarm = 1'b1;
    tick();
    arm = 1'b0;
    disarm = 1'b0;
    chk("t5_both", 64'(st0), 64'd0);

    // Async reset mid-drain
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (4) begin
      bus_rd(rand_addr());
      tick();
    end
    bus_rd(16'h0200);
    tick();
    repeat (4) begin
      rnd_bus();
      tick();
    end
    rd_en = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_state", 64'(st0), 64'd0);
    chk("t6_rst_count", 64'(tc0), 64'd0);
    chk("t6_rst_valid", 64'(tv0), 64'd0);
    chk("t6_rst_small", 64'(st1), 64'd0);
    rd_en = 1'b0;
    tick();
    resetn = 1'b1;

    // Randomized traffic against the model
    trig_on_write = 1'($urandom);
    for (int n = 0; n < 600; n++) begin
      arm    = ($urandom % 15 == 0);
      disarm = ($urandom % 60 == 0);
      rd_en  = 1'($urandom);
      if ($urandom % 8 == 0) begin
        if ($urandom % 2 == 0) bus_rd(16'h0200);
        else bus_wr(16'h0200, 8'($urandom));
      end else begin
        rnd_bus();
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
